// File: rtl/hazard_ctrl.sv
// Hazard and stall sequencer for the five-stage core: load-use bubbles,
// redirect squashes, multi-cycle multiply occupancy of EX and terminal halt.
module hazard_ctrl #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_inst,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic [1:0]  ex_pc_src,
  input  logic        ex_mul_start,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_write,
  output logic        control_sel,
  output logic        flush_ifid,
  output logic        mul_busy,
  output logic        halted
);

  typedef enum logic [1:0] {S_RUN, S_MUL_WAIT, S_HALT} state_t;

  localparam logic [3:0] LP_CNT_INIT  = 4'(MUL_LAT - 1);
  localparam bit         LP_MUL_MULTI = (MUL_LAT > 1);
  localparam logic [6:0] OP_HALT      = 7'b1111111;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;

  logic [6:0] w_opcode;
  logic [4:0] w_rs1, w_rs2;
  logic       w_uses_rs1, w_uses_rs2, w_lu, w_redirect;
  logic       w_unused_bits;

  assign w_opcode      = id_inst[6:0];
  assign w_rs1         = id_inst[19:15];
  assign w_rs2         = id_inst[24:20];
  assign w_unused_bits = ^{id_inst[31:25], id_inst[14:7]};

  always_comb begin
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    case (w_opcode)
      7'b1100111, 7'b0000011, 7'b0010011: w_uses_rs1 = 1'b1;
      7'b1100011, 7'b0110011, 7'b0100011: begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  // x0 is never a real producer, so a load to x0 cannot create a hazard.
  assign w_lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((w_uses_rs1 && (ex_rd == w_rs1)) ||
                 (w_uses_rs2 && (ex_rd == w_rs2)));
  assign w_redirect = (ex_pc_src == 2'b01);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    control_sel = 1'b0;
    flush_ifid  = 1'b0;
    mul_busy    = 1'b0;
    halted      = 1'b0;

    case (r_state)
      S_RUN: begin
        // A single-cycle mul needs no stall and falls through to the other rules.
        if (ex_mul_start && LP_MUL_MULTI) begin
          w_state_nxt = S_MUL_WAIT;
          w_cnt_nxt   = LP_CNT_INIT;
        end else if (w_redirect) begin
          flush_ifid  = 1'b1;
          control_sel = 1'b1;
        end else if (w_lu) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          control_sel = 1'b1;
        end else if (w_opcode == OP_HALT) begin
          w_state_nxt = S_HALT;
        end
      end

      S_MUL_WAIT: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_write = 1'b0;
        mul_busy   = 1'b1;
        w_cnt_nxt  = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = S_RUN;
      end

      S_HALT: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        control_sel = 1'b1;
        halted      = 1'b1;
      end

      default: begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = 4'd0;
      end
    endcase

    // Reset freezes fetch and bubbles the pipe regardless of state.
    if (rst) begin
      w_state_nxt = S_RUN;
      w_cnt_nxt   = 4'd0;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b1;
      control_sel = 1'b1;
      flush_ifid  = 1'b1;
      mul_busy    = 1'b0;
      halted      = 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (MUL_LAT 3, 1, 4) share stimulus and
// are compared each cycle against a remaining-stall-cycles reference model.
module tb_hazard_ctrl;

  localparam int LATS [3] = '{3, 1, 4};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_inst;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_pc_src;
  logic        ex_mul_start;

  // {pc_write, ifid_write, idex_write, control_sel, flush_ifid, mul_busy, halted}
  logic [2:0][6:0] dout;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl #(.MUL_LAT(LATS[g])) u_dut (
      .clk         (clk),
      .rst         (rst),
      .id_inst     (id_inst),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .ex_pc_src   (ex_pc_src),
      .ex_mul_start(ex_mul_start),
      .pc_write    (dout[g][6]),
      .ifid_write  (dout[g][5]),
      .idex_write  (dout[g][4]),
      .control_sel (dout[g][3]),
      .flush_ifid  (dout[g][2]),
      .mul_busy    (dout[g][1]),
      .halted      (dout[g][0])
    );
  end

  always #5 clk = ~clk;

  localparam logic [6:0] E_RST  = 7'b0011100;
  localparam logic [6:0] E_NORM = 7'b1110000;
  localparam logic [6:0] E_LU   = 7'b0011000;
  localparam logic [6:0] E_REDR = 7'b1111100;
  localparam logic [6:0] E_HALT = 7'b0011001;
  localparam logic [6:0] E_BUSY = 7'b0000010;

  int checks = 0;
  int errors = 0;

  // Model: cycles of mul stall still owed, and whether the core has halted.
  int   m_left [3] = '{0, 0, 0};
  bit   m_halt [3] = '{0, 0, 0};
  logic [6:0] smp [3];

  function automatic bit m_lu();
    logic [6:0] op;
    bit u1, u2;
    op = id_inst[6:0];
    u1 = op inside {7'b1100111, 7'b1100011, 7'b0110011, 7'b0000011, 7'b0100011, 7'b0010011};
    u2 = op inside {7'b1100011, 7'b0110011, 7'b0100011};
    return ex_mem_read && ex_rd != 0 &&
           ((u1 && ex_rd == id_inst[19:15]) || (u2 && ex_rd == id_inst[24:20]));
  endfunction

  function automatic logic [6:0] m_out(input int k);
    if (rst)                             return E_RST;
    if (m_halt[k])                       return E_HALT;
    if (m_left[k] > 0)                   return E_BUSY;
    if (ex_mul_start && LATS[k] > 1)     return E_NORM;
    if (ex_pc_src == 2'b01)              return E_REDR;
    if (m_lu())                          return E_LU;
    return E_NORM;
  endfunction

  function automatic void m_update(input int k);
    if (rst) begin
      m_left[k] = 0;
      m_halt[k] = 0;
    end else if (m_halt[k]) begin
      m_halt[k] = 1;
    end else if (m_left[k] > 0) begin
      m_left[k] = m_left[k] - 1;
    end else if (ex_mul_start && LATS[k] > 1) begin
      m_left[k] = LATS[k] - 1;
    end else if (ex_pc_src != 2'b01 && !m_lu() && id_inst[6:0] == 7'h7F) begin
      m_halt[k] = 1;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // One cycle: compare all instances to the model mid-cycle, then advance.
  task automatic step(input string nm, input bit use_t = 1'b0, input int tk = 0,
                      input logic [6:0] texp = '0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      smp[k] = dout[k];
      chk($sformatf("%s/dut%0d", nm, k), 32'(dout[k]), 32'(m_out(k)));
    end
    if (use_t) chk({nm, "_tbl"}, 32'(dout[tk]), 32'(texp));
    @(posedge clk);
    for (int k = 0; k < 3; k++) m_update(k);
    #1;
  endtask

  task automatic drive(input logic r, input logic [31:0] inst, input logic mr,
                       input logic [4:0] rd, input logic [1:0] src, input logic mul);
    rst = r; id_inst = inst; ex_mem_read = mr; ex_rd = rd; ex_pc_src = src; ex_mul_start = mul;
  endtask

  typedef struct {
    string       name;
    logic        r;
    logic [31:0] inst;
    logic        mr;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [6:0]  exp;
  } vec_t;

  localparam logic [31:0] ADD_356 = 32'h006281B3;  // add x3,x5,x6
  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [31:0] HALTI   = 32'h0000007F;

  vec_t tbl [$];
  int   busy_cnt [3];
  int   halt_cnt;

  initial begin
    tbl.push_back('{"rst",        1'b1, NOP,           1'b0, 5'd0, 2'b00, E_RST});
    tbl.push_back('{"reset_vals", 1'b0, 32'h0,         1'b0, 5'd0, 2'b00, E_NORM});
    tbl.push_back('{"lu_rs1",     1'b0, ADD_356,       1'b1, 5'd5, 2'b00, E_LU});
    tbl.push_back('{"lu_after",   1'b0, ADD_356,       1'b0, 5'd5, 2'b00, E_NORM});
    tbl.push_back('{"rd0_no_lu",  1'b0, ADD_356,       1'b1, 5'd0, 2'b00, E_NORM});
    tbl.push_back('{"rd0_rs1_x0", 1'b0, 32'h006001B3,  1'b1, 5'd0, 2'b00, E_NORM});
    tbl.push_back('{"lu_rs2",     1'b0, ADD_356,       1'b1, 5'd6, 2'b00, E_LU});
    tbl.push_back('{"lui_no_use", 1'b0, 32'h000282B7,  1'b1, 5'd5, 2'b00, E_NORM});
    tbl.push_back('{"addi_rs2",   1'b0, 32'h00500093,  1'b1, 5'd5, 2'b00, E_NORM});
    tbl.push_back('{"sw_rs2",     1'b0, 32'h00502023,  1'b1, 5'd5, 2'b00, E_LU});
    tbl.push_back('{"redir_lu",   1'b0, ADD_356,       1'b1, 5'd5, 2'b01, E_REDR});
    tbl.push_back('{"src10_lu",   1'b0, ADD_356,       1'b1, 5'd5, 2'b10, E_LU});
    tbl.push_back('{"src11",      1'b0, ADD_356,       1'b0, 5'd5, 2'b11, E_NORM});
    tbl.push_back('{"jalr_lu",    1'b0, 32'h00028067,  1'b1, 5'd5, 2'b00, E_LU});

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].inst, tbl[i].mr, tbl[i].rd, tbl[i].src, 1'b0);
      step(tbl[i].name, 1'b1, 0, tbl[i].exp);
    end

    // Mul occupancy: stall length depends on MUL_LAT per instance.
    drive(0, NOP, 0, 0, 2'b00, 1);
    step("mul_start", 1'b1, 0, E_NORM);
    busy_cnt = '{0, 0, 0};
    drive(0, NOP, 0, 0, 2'b00, 0);
    for (int c = 0; c < 5; c++) begin
      step("mul_wait");
      for (int k = 0; k < 3; k++) busy_cnt[k] += int'(smp[k][1]);
    end
    chk("mul_busy_lat3", busy_cnt[0], 2);
    chk("mul_busy_lat1", busy_cnt[1], 0);
    chk("mul_busy_lat4", busy_cnt[2], 3);

    // Reset while the MUL_LAT=4 instance sits at its last wait cycle.
    drive(0, NOP, 0, 0, 2'b00, 1);
    step("rmw_start");
    drive(0, NOP, 0, 0, 2'b00, 0);
    step("rmw_w3");
    step("rmw_w2", 1'b1, 2, E_BUSY);
    drive(1, NOP, 0, 0, 2'b00, 0);
    step("rmw_rst", 1'b1, 2, E_RST);
    drive(0, 32'h0, 0, 0, 2'b00, 0);
    step("rmw_after", 1'b1, 2, E_NORM);

    // Plain halt.
    drive(0, HALTI, 0, 0, 2'b00, 0);
    step("halt_pass", 1'b1, 0, E_NORM);
    drive(0, NOP, 0, 0, 2'b00, 0);
    halt_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      drive(0, NOP, c[0], 5'(c), 2'(c), c[1]);
      step("halt_hold");
      halt_cnt += int'(smp[0] == E_HALT);
    end
    chk("halt_held20", halt_cnt, 20);

    drive(1, NOP, 0, 0, 2'b00, 0);
    step("halt_rst");
    drive(0, 32'h0, 0, 0, 2'b00, 0);
    step("halt_after_rst", 1'b1, 0, E_NORM);

    // Halt in ID together with a mul entering EX: stall first, then halt.
    drive(0, HALTI, 0, 0, 2'b00, 1);
    step("hm_start", 1'b1, 0, E_NORM);
    drive(0, HALTI, 0, 0, 2'b00, 0);
    step("hm_w1", 1'b1, 0, E_BUSY);
    step("hm_w2", 1'b1, 0, E_BUSY);
    step("hm_run", 1'b1, 0, E_NORM);
    step("hm_halted", 1'b1, 0, E_HALT);
    step("hm_halted2", 1'b1, 2, E_HALT);
    drive(1, NOP, 0, 0, 2'b00, 0);
    step("hm_rst");

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      logic [6:0] ops [7] = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011,
                              7'b0010011, 7'b1100111, 7'b0110111};
      logic [6:0] op;
      logic [31:0] inst;
      logic mr, mul;
      logic [1:0] src;
      op  = ($urandom_range(0, 29) == 0) ? 7'h7F : ops[$urandom_range(0, 6)];
      mr  = 1'($urandom);
      src = 2'($urandom);
      mul = ($urandom_range(0, 9) == 0);
      if (mul) begin
        mr = 1'b0;
        if (src == 2'b01) src = 2'b00;
        if (op == 7'h7F) op = 7'b0010011;
      end
      inst = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              3'($urandom), 5'($urandom), op};
      drive(($urandom_range(0, 24) == 0), inst, mr, 5'($urandom_range(0, 7)), src, mul);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
